// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
// Imported by rr_pick and rr_mux_arbiter.
package rr_arb_pkg;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned DEF_W = 8;

  typedef logic [$clog2(DEF_N)-1:0] src_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: the first valid index starting at ptr.
// Purely combinational.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int SW = 2
) (
  input  logic [N-1:0]  in_valid,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] winner,
  output logic          any_valid
);

  int idx;

  // Scan from the farthest offset down so the closest match to ptr wins.
  always_comb begin
    idx       = 0;
    winner    = '0;
    any_valid = |in_valid;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (in_valid[idx]) winner = SW'(idx);
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-input round-robin arbiter feeding a single registered output slot.
// The slot reloads in the same cycle it is consumed.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int W  = DEF_W,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic          out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  input  logic          out_ready
);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] src_q, src_d;
  logic [W-1:0]  data_q, data_d;

  logic [SW-1:0] win;
  logic [W-1:0]  win_data;
  logic          any_v;
  logic          can_load;
  logic          load;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .in_valid  (in_valid),
    .ptr       (ptr_q),
    .winner    (win),
    .any_valid (any_v)
  );

  assign can_load = (state_q == EMPTY) || out_ready;
  assign load     = can_load && any_v;

  always_comb begin
    win_data = in_data[int'(win)*W +: W];
  end

  // Gated by rst_n so no grant is visible while reset is held.
  always_comb begin
    in_ready = '0;
    if (rst_n && load) in_ready[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = win_data;
      src_d   = win;
      ptr_d   = (win == SW'(N - 1)) ? '0 : win + 1'b1;
    end else if (can_load) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=8).
// Expected values are hand-computed per vector.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  int n_cmp;
  int n_bad;

  rr_mux_arbiter #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rst_n  = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ptr", 32'(dut.ptr_q), 0);
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // single requester
    in_valid  = 4'b0100;
    in_data   = 32'h00A5_0000;
    out_ready = 1'b1;
    #1;
    chk("single_in_ready", 32'(in_ready), 32'h4);
    step();
    in_valid = 4'b0000;
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_src", 32'(out_src), 2);
    chk("single_ptr", 32'(dut.ptr_q), 3);

    // drain
    step();
    chk("drain_valid", 32'(out_valid), 0);

    // all four valid from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    in_data  = 32'h1312_1110;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_grant", 32'(in_ready), 32'(1 << (k % 4)));
      step();
      chk("rr_src", 32'(out_src), 32'(k % 4));
      chk("rr_data", 32'(out_data), 32'(8'h10 + k % 4));
      chk("rr_valid", 32'(out_valid), 1);
    end

    // backpressure while holding 8'h11 from requester 1
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      step();
      chk("bp_data", 32'(out_data), 32'h11);
      chk("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_grant", 32'(in_ready), 32'h4);
    step();
    chk("bp_rel_src", 32'(out_src), 2);
    chk("bp_rel_data", 32'(out_data), 32'h12);
    chk("bp_rel_ptr", 32'(dut.ptr_q), 3);

    // wrap from ptr=3
    in_valid = 4'b1001;
    #1;
    chk("wrap_grant3", 32'(in_ready), 32'h8);
    step();
    chk("wrap_src3", 32'(out_src), 3);
    chk("wrap_data3", 32'(out_data), 32'h13);
    chk("wrap_ptr0", 32'(dut.ptr_q), 0);
    chk("wrap_grant0", 32'(in_ready), 32'h1);
    step();
    chk("wrap_src0", 32'(out_src), 0);
    chk("wrap_data0", 32'(out_data), 32'h10);

    // reset mid-operation while FULL
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #2 rst_n  = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_ptr", 32'(dut.ptr_q), 0);
    step();
    chk("mid_rst_no_beat", 32'(out_valid), 0);

    // first load after release
    in_valid = 4'b0010;
    #1;
    chk("post_rst_grant", 32'(in_ready), 32'h2);
    step();
    in_valid = 4'b0000;
    chk("post_rst_src", 32'(out_src), 1);
    chk("post_rst_data", 32'(out_data), 32'h11);
    chk("post_rst_ptr", 32'(dut.ptr_q), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
